// File: rtl/gfsk_demod_integrate_dump.sv
// -----------------------------------------------------------------------------
// gfsk_demod_integrate_dump
//
// Oversampled GFSK discriminator with integrate-and-dump symbol decision.
// Each accepted I/Q sample is cross-multiplied with the sample DIFF_LAG
// strobes earlier, which gives a per-sample frequency metric. The metric is
// summed over SAMPLES_PER_SYMBOL samples, and one hard bit is emitted per
// symbol. The symbol phase can be realigned at run time with phase_clear.
//
// Optional feature: define GFSK_DEMOD_OFFSET_TRACK_EN to enable a leaky
// integrator that tracks the DC frequency offset. The integrator is updated
// once per symbol and subtracted from the decision metric.
//
// Ports:
//   clk                 clock
//   rst                 asynchronous active-high reset
//   i, q                signed I/Q sample (IQ_BIT_WIDTH bits)
//   iq_valid            sample strobe, arbitrary gaps allowed
//   phase_clear         with iq_valid: current sample is symbol phase 0
//   disc                signed per-sample discriminator (2W+1 bits)
//   disc_valid          disc strobe
//   signal_for_decision signed symbol metric (2W+1+log2(S) bits)
//   phy_bit             hard decision (metric > 0)
//   bit_valid           one-cycle pulse per completed symbol
//   freq_offset         signed offset estimate (0 without the feature)
//
// Pipeline: stage 1 = delay line / phase tag, stage 2 = cross product,
// stage 3 = integrate and decide.
// -----------------------------------------------------------------------------
module gfsk_demod_integrate_dump #(
  parameter int IQ_BIT_WIDTH       = 4,
  parameter int SAMPLES_PER_SYMBOL = 8,
  parameter int DIFF_LAG           = 1,
  parameter int OFFSET_SHIFT       = 3
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic signed [IQ_BIT_WIDTH-1:0]                            i,
  input  logic signed [IQ_BIT_WIDTH-1:0]                            q,
  input  logic                                                      iq_valid,
  input  logic                                                      phase_clear,
  output logic signed [2*IQ_BIT_WIDTH:0]                            disc,
  output logic                                                      disc_valid,
  output logic signed [2*IQ_BIT_WIDTH+$clog2(SAMPLES_PER_SYMBOL):0] signal_for_decision,
  output logic                                                      phy_bit,
  output logic                                                      bit_valid,
  output logic signed [2*IQ_BIT_WIDTH+$clog2(SAMPLES_PER_SYMBOL):0] freq_offset
);

  localparam int W  = IQ_BIT_WIDTH;
  localparam int S  = SAMPLES_PER_SYMBOL;
  localparam int L  = DIFF_LAG;
  localparam int DW = 2 * W + 1;
  localparam int A  = DW + $clog2(S);
  localparam int PW = (S > 1) ? $clog2(S) : 1;

  if (W < 2 || W > 16 || S < 1 || S > 32 || (S & (S - 1)) != 0 ||
      L < 1 || L > S || OFFSET_SHIFT < 1 || OFFSET_SHIFT > 8) begin : g_param_check
    $error("gfsk_demod_integrate_dump: parameter out of range");
  end

  // Full-precision cross product; the 2W+1 width cannot overflow.
  function automatic logic signed [DW-1:0] cross_prod(
    input logic signed [W-1:0] i_old,
    input logic signed [W-1:0] q_new,
    input logic signed [W-1:0] i_new,
    input logic signed [W-1:0] q_old
  );
    logic signed [DW-1:0] a, b, c, d;
    a = i_old;
    b = q_new;
    c = i_new;
    d = q_old;
    return (a * b) - (c * d);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: delay line, phase tag
  // ---------------------------------------------------------------------------
  logic signed [W-1:0]  dly_i_q [L];
  logic signed [W-1:0]  dly_q_q [L];
  logic [PW-1:0]        phase_q;
  logic [PW-1:0]        phase_d;
  logic                 first_d;
  logic                 last_d;

  logic                 vld_p1_q;
  logic signed [W-1:0]  cur_i_p1_q;
  logic signed [W-1:0]  cur_q_p1_q;
  logic signed [W-1:0]  old_i_p1_q;
  logic signed [W-1:0]  old_q_p1_q;
  logic                 first_p1_q;
  logic                 last_p1_q;

  // With S=1 every sample is phase 0 and therefore also the last one.
  always_comb begin
    phase_d = '0;
    if (!phase_clear && S > 1) begin
      phase_d = phase_q + PW'(1);
    end
    first_d = (phase_d == '0);
    last_d  = (phase_d == PW'(S - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < L; k++) begin
        dly_i_q[k] <= '0;
        dly_q_q[k] <= '0;
      end
      phase_q    <= '0;
      vld_p1_q   <= 1'b0;
      cur_i_p1_q <= '0;
      cur_q_p1_q <= '0;
      old_i_p1_q <= '0;
      old_q_p1_q <= '0;
      first_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
    end else begin
      vld_p1_q <= iq_valid;
      if (iq_valid) begin
        cur_i_p1_q <= i;
        cur_q_p1_q <= q;
        old_i_p1_q <= dly_i_q[L-1];
        old_q_p1_q <= dly_q_q[L-1];
        dly_i_q[0] <= i;
        dly_q_q[0] <= q;
        for (int k = 1; k < L; k++) begin
          dly_i_q[k] <= dly_i_q[k-1];
          dly_q_q[k] <= dly_q_q[k-1];
        end
        phase_q    <= phase_d;
        first_p1_q <= first_d;
        last_p1_q  <= last_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: discriminator
  // ---------------------------------------------------------------------------
  logic                 vld_p2_q;
  logic signed [DW-1:0] disc_p2_q;
  logic                 first_p2_q;
  logic                 last_p2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q   <= 1'b0;
      disc_p2_q  <= '0;
      first_p2_q <= 1'b0;
      last_p2_q  <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        disc_p2_q  <= cross_prod(old_i_p1_q, cur_q_p1_q, cur_i_p1_q, old_q_p1_q);
        first_p2_q <= first_p1_q;
        last_p2_q  <= last_p1_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: integrate and dump, decision
  // ---------------------------------------------------------------------------
  logic signed [A-1:0]  acc_q;
  logic signed [A-1:0]  disc_ext;
  logic signed [A-1:0]  acc_total;
  logic signed [A-1:0]  metric_d;
  logic signed [A-1:0]  offset_est;
  logic signed [A-1:0]  metric_p3_q;
  logic                 bit_p3_q;
  logic                 vld_p3_q;
  logic                 dump;

  assign disc_ext = disc_p2_q;
  assign dump     = vld_p2_q && last_p2_q;

  // acc_total includes the current sample so the dump needs no extra cycle.
  always_comb begin
    acc_total = first_p2_q ? disc_ext : (acc_q + disc_ext);
    metric_d  = acc_total - offset_est;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      metric_p3_q <= '0;
      bit_p3_q    <= 1'b0;
      vld_p3_q    <= 1'b0;
    end else begin
      vld_p3_q <= dump;
      if (vld_p2_q) begin
        acc_q <= acc_total;
      end
      if (dump) begin
        metric_p3_q <= metric_d;
        bit_p3_q    <= (metric_d > 0);
      end
    end
  end

`ifdef GFSK_DEMOD_OFFSET_TRACK_EN
  // Leaky integrator; the decision above already used the pre-update value.
  logic signed [A-1:0] offset_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q <= '0;
    end else if (dump) begin
      offset_q <= offset_q + (metric_d >>> OFFSET_SHIFT);
    end
  end

  assign offset_est = offset_q;
`else
  assign offset_est = '0;
`endif

  assign disc                = disc_p2_q;
  assign disc_valid          = vld_p2_q;
  assign signal_for_decision = metric_p3_q;
  assign phy_bit             = bit_p3_q;
  assign bit_valid           = vld_p3_q;
  assign freq_offset         = offset_est;

endmodule

// File: tb/tb_gfsk_demod_integrate_dump.sv
module tb_gfsk_demod_integrate_dump;

  localparam int W = 4;
  localparam int S = 8;
  localparam int A = 2 * W + 1 + 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic signed [W-1:0]   i = '0;
  logic signed [W-1:0]   q = '0;
  logic                  iq_valid = 1'b0;
  logic                  phase_clear = 1'b0;
  logic signed [2*W:0]   disc;
  logic                  disc_valid;
  logic signed [A-1:0]   signal_for_decision;
  logic                  phy_bit;
  logic                  bit_valid;
  logic signed [A-1:0]   freq_offset;

  gfsk_demod_integrate_dump #(
    .IQ_BIT_WIDTH      (W),
    .SAMPLES_PER_SYMBOL(S),
    .DIFF_LAG          (1),
    .OFFSET_SHIFT      (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i                  (i),
    .q                  (q),
    .iq_valid           (iq_valid),
    .phase_clear        (phase_clear),
    .disc               (disc),
    .disc_valid         (disc_valid),
    .signal_for_decision(signal_for_decision),
    .phy_bit            (phy_bit),
    .bit_valid          (bit_valid),
    .freq_offset        (freq_offset)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sfd;
    int b;
    int fo;
    int cyc;
  } bit_exp_t;

  int       dq[$];
  bit_exp_t bq[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  int       bits_seen = 0;

  int ccw_i[4] = '{7, 0, -7, 0};
  int ccw_q[4] = '{0, 7, 0, -7};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (disc_valid) begin
      if (dq.size() == 0) begin
        chk("disc_unexpected", 1, 0);
      end else begin
        chk("disc", int'(disc), dq.pop_front());
      end
    end
    if (bit_valid) begin
      bits_seen++;
      if (bq.size() == 0) begin
        chk("bit_unexpected", 1, 0);
      end else begin
        bit_exp_t e;
        e = bq.pop_front();
        chk("signal_for_decision", int'(signal_for_decision), e.sfd);
        chk("phy_bit", int'(phy_bit), e.b);
        chk("freq_offset", int'(freq_offset), e.fo);
        if (e.cyc >= 0) chk("bit_latency", cyc, e.cyc);
      end
    end
  end

  // One sample on the next negedge; iq_valid stays high until the next call.
  task automatic send(input int si, input int sq, input bit pc, input int ed,
                      input bit last, input int esfd, input int efo, input bit chkcyc);
    bit_exp_t e;
    @(negedge clk);
    i           = si[W-1:0];
    q           = sq[W-1:0];
    iq_valid    = 1'b1;
    phase_clear = pc;
    dq.push_back(ed);
    if (last) begin
      e.sfd = esfd;
      e.b   = (esfd > 0) ? 1 : 0;
      e.fo  = efo;
      e.cyc = chkcyc ? cyc + 3 : -1;
      bq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iq_valid    = 1'b0;
      phase_clear = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    iq_valid    = 1'b0;
    phase_clear = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_disc"}, int'(disc), 0);
    chk({tag, "_disc_valid"}, int'(disc_valid), 0);
    chk({tag, "_sfd"}, int'(signal_for_decision), 0);
    chk({tag, "_phy_bit"}, int'(phy_bit), 0);
    chk({tag, "_bit_valid"}, int'(bit_valid), 0);
    chk({tag, "_freq_offset"}, int'(freq_offset), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Constant tone: no rotation, zero metric.
    for (int k = 0; k < 16; k++)
      send(7, 0, k == 0, 0, (k % 8) == 7, 0, 0, 1'b1);
    idle(5);

`ifdef GFSK_DEMOD_OFFSET_TRACK_EN
    // Offset tracking, k=2, continuous CCW; first sample is a partial symbol.
    do_reset();
    for (int k = 0; k <= 24; k++)
      send(ccw_i[k % 4], ccw_q[k % 4], k == 1, (k == 0) ? 0 : 49,
           k == 8 || k == 16 || k == 24,
           (k == 8) ? 392 : (k == 16) ? 294 : 221,
           (k == 8) ? 98 : (k == 16) ? 171 : 226, 1'b1);
    idle(5);
`else
    // CCW rotation, back-to-back samples, clear on sample 1.
    do_reset();
    for (int k = 0; k <= 16; k++)
      send(ccw_i[k % 4], ccw_q[k % 4], k == 1, (k == 0) ? 0 : 49,
           k == 8 || k == 16, 392, 0, 1'b1);
    idle(5);

    // CW rotation with random gaps.
    do_reset();
    b0 = bits_seen;
    for (int k = 0; k <= 16; k++) begin
      send(ccw_i[k % 4], -ccw_q[k % 4], k == 1, (k == 0) ? 0 : -49,
           k == 8 || k == 16, -392, 0, 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(5);
    chk("cw_bit_count", bits_seen - b0, 2);

    // Re-clear at phase 5: the partial symbol yields no bit.
    do_reset();
    b0 = bits_seen;
    for (int k = 0; k <= 21; k++)
      send(ccw_i[k % 4], ccw_q[k % 4], k == 1 || k == 14, (k == 0) ? 0 : 49,
           k == 8 || k == 21, 392, 0, 1'b1);
    // Partial symbol, then reset mid-symbol.
    for (int k = 22; k <= 26; k++)
      send(ccw_i[k % 4], ccw_q[k % 4], 1'b0, 49, 1'b0, 0, 0, 1'b0);
    idle(4);
    chk("reclear_bit_count", bits_seen - b0, 2);
    chk("pre_reset_sfd", int'(signal_for_decision), 392);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    b0 = bits_seen;
    idle(3);
    chk("no_stale_bit", bits_seen - b0, 0);

    // Restart: zero history on the first sample.
    for (int k = 0; k < 8; k++)
      send(ccw_i[k % 4], ccw_q[k % 4], k == 0, (k == 0) ? 0 : 49,
           k == 7, 343, 0, 1'b1);
    idle(5);
`endif

    idle(5);
    chk("disc_queue_drained", dq.size(), 0);
    chk("bit_queue_drained", bq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
